// File: rtl/hc194_seq_ctrl_if.sv
// Word-in / HC_194-drive bundle for hc194_seq_ctrl.
// With HC194_SHL_EN defined the bundle also carries the shift-direction input dir.
interface hc194_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_mode;
`ifdef HC194_SHL_EN
  logic              dir;
`endif
  logic              S1;
  logic              S0;
  logic              DSR;
  logic              DSL;
  logic              D0;
  logic              D1;
  logic              D2;
  logic              D3;
  logic              nib_strobe;
  logic              busy;

`ifdef HC194_SHL_EN
  modport master (
    output in_data, in_valid, ser_mode, dir,
    input  in_ready, S1, S0, DSR, DSL, D0, D1, D2, D3, nib_strobe, busy
  );
  modport slave (
    input  in_data, in_valid, ser_mode, dir,
    output in_ready, S1, S0, DSR, DSL, D0, D1, D2, D3, nib_strobe, busy
  );
`else
  modport master (
    output in_data, in_valid, ser_mode,
    input  in_ready, S1, S0, DSR, DSL, D0, D1, D2, D3, nib_strobe, busy
  );
  modport slave (
    input  in_data, in_valid, ser_mode,
    output in_ready, S1, S0, DSR, DSL, D0, D1, D2, D3, nib_strobe, busy
  );
`endif
endinterface

// File: rtl/hc194_seq_ctrl.sv
// Splits accepted words into nibbles and writes each into an HC_194 by parallel load or four shifts.
// Optional macro HC194_SHL_EN adds a dir input selecting shift-left for serial transfers.
module hc194_seq_ctrl #(
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input logic             Clk,
  input logic             MR,
  hc194_seq_ctrl_if.slave ctrl_if
);

  localparam int NIB   = DATA_W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = $clog2(HOLD_CYC + 4);

  localparam logic [NIB_W-1:0] LAST_NIB  = NIB_W'(NIB - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(3);
  localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [NIB_W-1:0] NIB_ONE   = NIB_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NIB_W-1:0]  nib_q,   nib_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic              mode_q,  mode_d;
  logic              dir_q,   dir_d;

  logic              in_ready_int;
  logic              accept;
  logic              dir_in;

  // Output stage: next-cycle values and their registers
  logic [1:0]        s_d,      s_q;
  logic [3:0]        d_d,      d_q;
  logic              dsr_d,    dsr_q;
  logic              dsl_d,    dsl_q;
  logic              strobe_d, strobe_q;
  logic              busy_d,   busy_q;

  logic [3:0]        nib_arr [NIB];
  logic [3:0]        cur_nib;
  logic [1:0]        bit_sel;

  assign in_ready_int    = (state_q == IDLE) && !MR;
  assign accept          = ctrl_if.in_valid && in_ready_int;
  assign ctrl_if.in_ready = in_ready_int;

`ifdef HC194_SHL_EN
  assign dir_in = ctrl_if.dir;
`else
  assign dir_in = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (MR) begin
      state_q <= IDLE;
      nib_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic; cnt counts shift bits in SHIFT and hold cycles in HOLD
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = ctrl_if.in_data;
          mode_d  = ctrl_if.ser_mode;
          dir_d   = dir_in;
          nib_d   = '0;
          cnt_d   = '0;
          state_d = ctrl_if.ser_mode ? SHIFT : LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == LAST_HOLD) begin
          cnt_d = '0;
          if (nib_q != LAST_NIB) begin
            nib_d   = nib_q + NIB_ONE;
            state_d = mode_q ? SHIFT : LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign nib_arr[gi] = word_d[gi*4 +: 4];
  end

  assign cur_nib = nib_arr[nib_d];
  assign bit_sel = cnt_d[1:0];

  // Outputs are decoded from the next state so the registered pins line up with the FSM
  always_comb begin
    s_d      = 2'b00;
    d_d      = 4'b0000;
    dsr_d    = 1'b0;
    dsl_d    = 1'b0;
    strobe_d = 1'b0;
    busy_d   = (state_d != IDLE);
    unique case (state_d)
      LOAD: begin
        s_d = 2'b11;
        d_d = cur_nib;
      end
      SHIFT: begin
        if (dir_d) begin
          s_d   = 2'b10;
          dsl_d = cur_nib[bit_sel];
        end else begin
          s_d   = 2'b01;
          dsr_d = cur_nib[~bit_sel];
        end
      end
      HOLD:    strobe_d = 1'b1;
      default: s_d = 2'b00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (MR) begin
      s_q      <= 2'b00;
      d_q      <= 4'b0000;
      dsr_q    <= 1'b0;
      dsl_q    <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      s_q      <= s_d;
      d_q      <= d_d;
      dsr_q    <= dsr_d;
      dsl_q    <= dsl_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign ctrl_if.S1         = s_q[1];
  assign ctrl_if.S0         = s_q[0];
  assign ctrl_if.D0         = d_q[0];
  assign ctrl_if.D1         = d_q[1];
  assign ctrl_if.D2         = d_q[2];
  assign ctrl_if.D3         = d_q[3];
  assign ctrl_if.DSR        = dsr_q;
  assign ctrl_if.DSL        = dsl_q;
  assign ctrl_if.nib_strobe = strobe_q;
  assign ctrl_if.busy       = busy_q;

endmodule

// File: doc/hc194_seq_ctrl.md
Name: hc194_seq_ctrl

Overview:
Upstream sequencer for the 4-bit universal shift register (HC_194). It accepts a DATA_W-bit word over a valid/ready handshake and splits it into nibbles. Each nibble is written into the shift register by driving its mode, serial and parallel inputs, either as a parallel load or as four serial right shifts. A strobe marks each cycle in which the register holds a complete nibble, so downstream logic can sample Q0..Q3.

Parameters:
DATA_W, 8, input word width; must be a multiple of 4 and at least 4; NIB = DATA_W/4.
HOLD_CYC, 2, cycles each nibble is held (S1S0=00) after it is written; must be at least 1.

Ports:
Clk  in  1  clock; all logic on rising edge.
MR  in  1  reset, synchronous, active-high.
in_data  in  DATA_W  word to transfer.
in_valid  in  1  in_data valid.
in_ready  out  1  controller can accept a word.
ser_mode  in  1  sampled at accept; 1 = serial shift-in via DSR, 0 = parallel load.
S1, S0  out  1 each  HC_194 mode select (00 hold, 01 shift right, 10 shift left, 11 load).
DSR  out  1  serial right-shift data.
DSL  out  1  serial left-shift data.
D0, D1, D2, D3  out  1 each  parallel load data (D0 = nibble bit0).
nib_strobe  out  1  register holds a complete nibble this cycle.
busy  out  1  word in progress.

Behaviour:
- MR high at a rising edge: state = IDLE, nibble index = 0, hold counter = 0, captured word and mode cleared.
  - All outputs 0, including in_ready.
  - in_ready = 1 from the first cycle after MR deasserts.
- MR mid-word aborts the transfer. The partial word is dropped and never resumes.
- All outputs except in_ready are registered. in_ready = (state == IDLE) && !MR.
- Accept: in_valid && in_ready at an edge. At that edge in_data and ser_mode are captured, and the FSM goes to LOAD (ser_mode=0) or SHIFT (ser_mode=1).
- Nibble order: nibble 0 = in_data[3:0] first, up to nibble NIB-1.
- FSM states are IDLE, LOAD, SHIFT and HOLD.
  - IDLE: S1S0 = 00; busy = 0; D/DSR/DSL = 0.
  - LOAD: 1 cycle.
    - S1S0 = 11; D3..D0 = current nibble.
    - HC_194 captures at the end-of-cycle edge.
    - Next state: HOLD.
  - SHIFT: 4 cycles.
    - S1S0 = 01; DSR = nibble bit3, bit2, bit1, bit0 on successive cycles.
    - After the 4th edge the register holds Q0 = bit0 ... Q3 = bit3, identical to a parallel load.
    - Next state: HOLD.
  - HOLD: HOLD_CYC cycles.
    - S1S0 = 00.
    - nib_strobe = 1 in every HOLD cycle.
    - After the last HOLD cycle: if nibble index < NIB-1, increment the index and go to LOAD or SHIFT per the captured mode; otherwise go to IDLE.
- busy = 1 in LOAD, SHIFT and HOLD.
- Cycles per word: NIB*(1+HOLD_CYC) in parallel mode, NIB*(4+HOLD_CYC) in serial mode. IDLE lasts at least 1 cycle between words, so back-to-back in_valid is accepted every word period + 1.
- in_data and ser_mode changes while busy are ignored.
- DSL = 0 always unless the optional feature is enabled.

Optional Feature:
Macro HC194_SHL_EN.
- Defined: adds input port dir (1 bit), captured at accept together with ser_mode.
  - Serial mode with dir = 1 uses shift left: S1S0 = 10, DSL = bit0, bit1, bit2, bit3 on successive cycles; DSR = 0.
  - The final register contents are unchanged (Q0 = bit0 ... Q3 = bit3).
  - Parallel mode ignores dir.
- Undefined: no dir port; DSL tied 0; only shift right is used.

Test Plan:
- Reset: hold MR = 1 for 3 cycles with in_valid = 1 -> all outputs 0, in_ready = 0; cycle after release -> in_ready = 1, S1S0 = 00.
- Parallel word: in_data = 0xA5, ser_mode = 0, DATA_W = 8, HOLD_CYC = 2.
  - Cycle after accept: S1S0 = 11, D3..D0 = 0101.
  - Then 2 strobe cycles with a model HC_194 showing Q3..Q0 = 0101.
  - Then S1S0 = 11, D3..D0 = 1010, then 2 strobes with Q = 1010.
  - Then IDLE; busy high for exactly 6 cycles.
- Serial word: in_data = 0x3C, ser_mode = 1.
  - DSR sequence 1,1,0,0 with S1S0 = 01, then 2 strobes with Q = 1100.
  - Then DSR 0,0,1,1, then 2 strobes with Q = 0011.
  - busy high for 12 cycles.
- Handshake: in_valid held high with 0x11 then 0x22 -> second word accepted exactly 1 IDLE cycle after the first completes; in_data changes mid-word are ignored.
- Abort: MR = 1 during the 3rd SHIFT cycle of nibble 0 -> next cycle all outputs 0, no nib_strobe; a new word afterwards transfers correctly from nibble 0.
- HC194_SHL_EN defined: in_data = 0x09, ser_mode = 1, dir = 1 -> S1S0 = 10, DSL = 1,0,0,1 for nibble 9; model Q = 1001 at strobe; DSR stays 0.
